multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multicycle MIPS datapath: it sequences instruction fetch, decode, execute, memory access and write-back over several clocks. It also stalls on a memory ready handshake and drives every datapath mux/enable each cycle. It sits beside the datapath and reads only the opcode from the instruction register, the ALU Zero flag and the memory ready flag.

## Interface
- CNT_W, 32, width of retired-instruction counter
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous reset, active-high
- Opcode  in  6  Instruction[31:26] from IR; stable from DECODE until the next FETCH
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current read/write this cycle
- PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- State  out  4  current state encoding (debug)
- IllegalOp  out  1  sticky unsupported-opcode flag
- InstrCount  out  CNT_W  retired instructions
- One clock; reset is synchronous and active-high (Clk, Rst).

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BEQ 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Codes 12–15 are illegal; they go to FETCH next cycle.
- Outputs are Moore decode of the state, qualified only by MemReady and Zero as listed. Unlisted outputs are 0.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=MemReady. Next state is DECODE if MemReady, else FETCH.
- DECODE: ALUSrcB=11, so the branch target goes into ALUOut. Next state by Opcode:
  - 000000 → R_EX
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BEQ
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - any other opcode → FETCH, and IllegalOp is set.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Holds until MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1 → FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
- R_EX: ALUSrcA=1, ALUOp=10 → R_WB.
- R_WB: RegWrite=1, RegDst=1 → FETCH.
- BEQ: ALUSrcA=1, ALUOp=01, PCSource=01, PCWrite=Zero → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10 → ADDI_WB.
- ADDI_WB: RegWrite=1 → FETCH.
- InstrCount increments by 1 on each transition to FETCH from MEM_WB, MEM_WR (with MemReady), R_WB, BEQ, JUMP or ADDI_WB. It wraps modulo 2^CNT_W. Illegal opcodes are not counted.
- IllegalOp stays 1 until Rst.

## Timing
- Rst=1 at a rising edge gives the following, regardless of current state or pending memory access:
  - next state FETCH
  - InstrCount=0
  - IllegalOp=0
- While Rst is high, all control outputs are forced to 0 combinationally. State output reads 0.
- Zero-wait-state latencies, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle MemReady is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Outputs hold during the stall.
- MemReady is ignored in all other states.
- Zero is sampled only in BEQ.

## Structure
- Shared package holds:
  - state localparams
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp, ALUSrcB and PCSource encodings
- No sub-module is needed; the design is a single next-state/output always block pair plus the counter.

## Test plan
- Reset: Rst=1 mid-MEM_RD → next cycle State=0, InstrCount=0, IllegalOp=0, all outputs 0 during Rst.
- lw with MemReady tied 1 → states 0,1,2,3,4,0. RegWrite=MemtoReg=1 only in state 4. InstrCount +1.
- sw with MemReady low 2 cycles in MEM_WR → MemWrite held 3 cycles. No RegWrite. Total 6 cycles.
- beq: run once with Zero=1 and once with Zero=0 → PCWrite=1 with PCSource=01 in the Zero=1 run; PCWrite=0 in the Zero=0 run. 3 cycles each.
- R-type then j → ALUOp=10 in R_EX, RegDst=RegWrite=1 in R_WB. JUMP gives PCSource=10, PCWrite=1. InstrCount +2.
- Opcode 111111 → DECODE returns to FETCH, IllegalOp=1 and stays 1, InstrCount unchanged. Preload InstrCount=2^32−1 and retire one instruction → InstrCount=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state
// encodings, supported opcodes and the datapath mux select encodings.
package multicycle_controller_pkg;

    // State codes are visible on the debug State port, so the values are fixed.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/write-back, stalls on MemReady in
// FETCH, MEM_RD and MEM_WR, and drives every datapath control each cycle.
// Ports:
//   Clk, Rst             clock and synchronous active-high reset
//   Opcode               IR[31:26], stable from DECODE to next FETCH
//   Zero                 ALU zero flag (used only in BEQ)
//   MemReady             memory completed the current access this cycle
//   PCWrite..PCSource    datapath mux selects and write enables
//   State                current state code (debug)
//   IllegalOp            sticky flag, set when DECODE sees an unsupported opcode
//   InstrCount           retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;
    logic               bad_op;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        retire   = 1'b0;
        bad_op   = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REGB;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR and PC load only when the instruction word is actually there.
                IRWrite = MemReady;
                PCWrite = MemReady;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcB = SRCB_IMM_SH2;
                case (Opcode)
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d = S_FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = MemReady;
                state_d  = MemReady ? S_FETCH : S_MEM_WR;
            end
            S_R_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = Zero;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            // Codes 12-15 are unreachable in normal operation; recover to FETCH.
            default: state_d = S_FETCH;
        endcase

        // Reset silences the datapath immediately, not just after the edge.
        if (Rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            RegDst   = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_REGB;
            ALUOp    = ALUOP_ADD;
            PCSource = PCSRC_ALU;
        end
    end

    assign illegal_d  = illegal_q | bad_op;
    assign cnt_d      = retire ? cnt_q + CNT_W'(1) : cnt_q;

    assign State      = Rst ? 4'd0 : state_q;
    assign IllegalOp  = illegal_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a cycle-by-cycle vector table
// plus hand-written jump-latency and FETCH-stall sequences. A second
// instance with a 3-bit counter runs on the same stimulus so the
// counter wrap is reached in a short run.
module tb_multicycle_controller;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;

    logic PCWrite_a, IRWrite_a, IorD_a, MemRead_a, MemWrite_a, MemtoReg_a;
    logic RegDst_a, RegWrite_a, ALUSrcA_a, IllegalOp_a;
    logic [1:0] ALUSrcB_a, ALUOp_a, PCSource_a;
    logic [3:0] State_a;
    logic [31:0] InstrCount_a;

    logic PCWrite_b, IRWrite_b, IorD_b, MemRead_b, MemWrite_b, MemtoReg_b;
    logic RegDst_b, RegWrite_b, ALUSrcA_b, IllegalOp_b;
    logic [1:0] ALUSrcB_b, ALUOp_b, PCSource_b;
    logic [3:0] State_b;
    logic [2:0] InstrCount_b;

    multicycle_controller #(.CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite_a), .IRWrite(IRWrite_a), .IorD(IorD_a), .MemRead(MemRead_a),
        .MemWrite(MemWrite_a), .MemtoReg(MemtoReg_a), .RegDst(RegDst_a),
        .RegWrite(RegWrite_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
        .ALUOp(ALUOp_a), .PCSource(PCSource_a), .State(State_a),
        .IllegalOp(IllegalOp_a), .InstrCount(InstrCount_a)
    );

    multicycle_controller #(.CNT_W(3)) dut_w3 (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite_b), .IRWrite(IRWrite_b), .IorD(IorD_b), .MemRead(MemRead_b),
        .MemWrite(MemWrite_b), .MemtoReg(MemtoReg_b), .RegDst(RegDst_b),
        .RegWrite(RegWrite_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
        .ALUOp(ALUOp_b), .PCSource(PCSource_b), .State(State_b),
        .IllegalOp(IllegalOp_b), .InstrCount(InstrCount_b)
    );

    always #5 Clk = ~Clk;

    // Control word: {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegDst,
    //                RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    logic [14:0] ctl_a, ctl_b;
    assign ctl_a = {PCWrite_a, IRWrite_a, IorD_a, MemRead_a, MemWrite_a, MemtoReg_a,
                    RegDst_a, RegWrite_a, ALUSrcA_a, ALUSrcB_a, ALUOp_a, PCSource_a};
    assign ctl_b = {PCWrite_b, IRWrite_b, IorD_b, MemRead_b, MemWrite_b, MemtoReg_b,
                    RegDst_b, RegWrite_b, ALUSrcA_b, ALUSrcB_b, ALUOp_b, PCSource_b};

    function automatic logic [14:0] mk(input logic pcw, input logic irw, input logic iord,
                                        input logic mrd, input logic mwr, input logic m2r,
                                        input logic rd, input logic rw, input logic asa,
                                        input logic [1:0] asb, input logic [1:0] aop,
                                        input logic [1:0] pcs);
        return {pcw, irw, iord, mrd, mwr, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        cs;    // check IllegalOp/InstrCount on this row
        logic [31:0] cnt;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                       input logic mr, input logic [3:0] st, input logic [14:0] ctl,
                       input logic cs, input logic [31:0] cnt, input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = zero; v.mr = mr; v.st = st;
        v.ctl = ctl; v.cs = cs; v.cnt = cnt; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] RT = 6'b000000, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    logic [14:0] C_Z, C_F1, C_F0, C_DEC, C_MA, C_MRD, C_MWB, C_MWR;
    logic [14:0] C_REX, C_RWB, C_BEQ1, C_BEQ0, C_J, C_AEX, C_AWB;

    initial begin
        int cyc;
        C_Z    = 15'd0;
        //          pcw irw iord mrd mwr m2r rd rw asa asb    aop    pcs
        C_F1   = mk(1,  1,  0,   1,  0,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00);
        C_F0   = mk(0,  0,  0,   1,  0,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00);
        C_DEC  = mk(0,  0,  0,   0,  0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00);
        C_MA   = mk(0,  0,  0,   0,  0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00);
        C_MRD  = mk(0,  0,  1,   1,  0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00);
        C_MWB  = mk(0,  0,  0,   0,  0,  1,  0, 1, 0,  2'b00, 2'b00, 2'b00);
        C_MWR  = mk(0,  0,  1,   0,  1,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00);
        C_REX  = mk(0,  0,  0,   0,  0,  0,  0, 0, 1,  2'b00, 2'b10, 2'b00);
        C_RWB  = mk(0,  0,  0,   0,  0,  0,  1, 1, 0,  2'b00, 2'b00, 2'b00);
        C_BEQ1 = mk(1,  0,  0,   0,  0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01);
        C_BEQ0 = mk(0,  0,  0,   0,  0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01);
        C_J    = mk(1,  0,  0,   0,  0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b10);
        C_AEX  = mk(0,  0,  0,   0,  0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00);
        C_AWB  = mk(0,  0,  0,   0,  0,  0,  0, 1, 0,  2'b00, 2'b00, 2'b00);

        //   rst op    z  mr st    ctl     cs cnt ill
        add(1, LW,   0, 1, 4'd0, C_Z,    1, 0, 0);   // after one reset edge
        // lw, no wait states: 0,1,2,3,4
        add(0, LW,   0, 1, 4'd0, C_F1,   1, 0, 0);
        add(0, LW,   0, 1, 4'd1, C_DEC,  1, 0, 0);
        add(0, LW,   0, 1, 4'd2, C_MA,   1, 0, 0);
        add(0, LW,   0, 1, 4'd3, C_MRD,  1, 0, 0);
        add(0, LW,   0, 1, 4'd4, C_MWB,  1, 0, 0);
        // sw, MemReady low two cycles in MEM_WR
        add(0, SW,   0, 1, 4'd0, C_F1,   1, 1, 0);
        add(0, SW,   0, 1, 4'd1, C_DEC,  1, 1, 0);
        add(0, SW,   0, 1, 4'd2, C_MA,   1, 1, 0);
        add(0, SW,   0, 0, 4'd5, C_MWR,  1, 1, 0);
        add(0, SW,   0, 0, 4'd5, C_MWR,  1, 1, 0);
        add(0, SW,   0, 1, 4'd5, C_MWR,  1, 1, 0);
        // beq taken
        add(0, BEQ,  1, 1, 4'd0, C_F1,   1, 2, 0);
        add(0, BEQ,  1, 1, 4'd1, C_DEC,  1, 2, 0);
        add(0, BEQ,  1, 1, 4'd8, C_BEQ1, 1, 2, 0);
        // beq not taken
        add(0, BEQ,  0, 1, 4'd0, C_F1,   1, 3, 0);
        add(0, BEQ,  0, 1, 4'd1, C_DEC,  1, 3, 0);
        add(0, BEQ,  0, 1, 4'd8, C_BEQ0, 1, 3, 0);
        // R-type, Zero high and MemReady low must be ignored outside BEQ/stall states
        add(0, RT,   1, 1, 4'd0, C_F1,   1, 4, 0);
        add(0, RT,   1, 0, 4'd1, C_DEC,  1, 4, 0);
        add(0, RT,   1, 0, 4'd6, C_REX,  1, 4, 0);
        add(0, RT,   1, 0, 4'd7, C_RWB,  1, 4, 0);
        // j
        add(0, JMP,  0, 1, 4'd0, C_F1,   1, 5, 0);
        add(0, JMP,  0, 1, 4'd1, C_DEC,  1, 5, 0);
        add(0, JMP,  0, 0, 4'd9, C_J,    1, 5, 0);
        // addi
        add(0, ADDI, 0, 1, 4'd0, C_F1,   1, 6, 0);
        add(0, ADDI, 0, 1, 4'd1, C_DEC,  1, 6, 0);
        add(0, ADDI, 0, 1, 4'd10, C_AEX, 1, 6, 0);
        add(0, ADDI, 0, 1, 4'd11, C_AWB, 1, 6, 0);
        // FETCH stall, then an illegal opcode
        add(0, BAD,  0, 0, 4'd0, C_F0,   1, 7, 0);
        add(0, BAD,  0, 1, 4'd0, C_F1,   1, 7, 0);
        add(0, BAD,  0, 1, 4'd1, C_DEC,  1, 7, 0);
        // lw with one MEM_RD stall; IllegalOp stays set, count wraps in 3-bit copy
        add(0, LW,   0, 1, 4'd0, C_F1,   1, 7, 1);
        add(0, LW,   0, 1, 4'd1, C_DEC,  1, 7, 1);
        add(0, LW,   0, 1, 4'd2, C_MA,   1, 7, 1);
        add(0, LW,   0, 0, 4'd3, C_MRD,  1, 7, 1);
        add(0, LW,   0, 1, 4'd3, C_MRD,  1, 7, 1);
        add(0, LW,   0, 1, 4'd4, C_MWB,  1, 7, 1);
        // reset in the middle of a stalled MEM_RD
        add(0, LW,   0, 1, 4'd0, C_F1,   1, 8, 1);
        add(0, LW,   0, 0, 4'd1, C_DEC,  1, 8, 1);
        add(0, LW,   0, 0, 4'd2, C_MA,   1, 8, 1);
        add(0, LW,   0, 0, 4'd3, C_MRD,  1, 8, 1);
        add(1, LW,   0, 0, 4'd0, C_Z,    0, 0, 0);
        add(0, LW,   0, 1, 4'd0, C_F1,   1, 0, 0);

        Rst = 1'b1; Opcode = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i]) begin
            Rst = vecs[i].rst; Opcode = vecs[i].op;
            Zero = vecs[i].zero; MemReady = vecs[i].mr;
            #2;
            chk($sformatf("v%0d State", i),    {28'd0, State_a}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d ctl", i),      {17'd0, ctl_a},   {17'd0, vecs[i].ctl});
            chk($sformatf("v%0d w3.State", i), {28'd0, State_b}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d w3.ctl", i),   {17'd0, ctl_b},   {17'd0, vecs[i].ctl});
            if (vecs[i].cs) begin
                chk($sformatf("v%0d InstrCount", i), InstrCount_a, vecs[i].cnt);
                chk($sformatf("v%0d w3.InstrCount", i), {29'd0, InstrCount_b},
                    {29'd0, vecs[i].cnt[2:0]});
                chk($sformatf("v%0d IllegalOp", i), {31'd0, IllegalOp_a}, {31'd0, vecs[i].ill});
                chk($sformatf("v%0d w3.IllegalOp", i), {31'd0, IllegalOp_b}, {31'd0, vecs[i].ill});
            end
            @(posedge Clk); #1;
        end

        // Jump latency: FETCH back to FETCH in exactly 3 cycles, bounded wait.
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; Opcode = JMP; MemReady = 1'b1; Zero = 1'b0;
        cyc = 0;
        do begin
            @(posedge Clk); #1;
            cyc++;
        end while (State_a != 4'd0 && cyc < 10);
        chk("j latency", cyc, 3);
        chk("j InstrCount", InstrCount_a, 32'd1);
        chk("j w3.InstrCount", {29'd0, InstrCount_b}, 32'd1);

        // Long FETCH stall: outputs hold, no IR/PC load.
        MemReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("stall%0d State", k), {28'd0, State_a}, 32'd0);
            chk($sformatf("stall%0d ctl", k), {17'd0, ctl_a}, {17'd0, C_F0});
            @(posedge Clk); #1;
        end
        MemReady = 1'b1;
        #2;
        chk("stall release ctl", {17'd0, ctl_a}, {17'd0, C_F1});
        @(posedge Clk); #1;
        chk("stall release State", {28'd0, State_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
